instr_decode_stage: RTL and testbench

//  Registered RV32I decode stage between fetch and execute; successor to the combinational imm_src decoder.

---
 rtl/decode_pkg.sv | 52 +++++
 rtl/imm_gen.sv | 29 ++
 rtl/instr_decode_stage.sv | 169 ++++++++++++++++
 tb/tb_instr_decode_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - RV32I decode encodings and the control bundle type
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MULD = 7'b0000001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Base ops reuse funct3 as the low bits; SUB/SRA set bit 3 like instr[30].
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;
    logic       alu_src;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational immediate generator, sign-extended from instr[31]
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm
);

  // Built at 64 bits then truncated, so every format (U included) sign-extends for XLEN>32.
  logic [63:0] ext;

  always_comb begin
    ext = '0;
    case (imm_src)
      IMM_I: ext = {{52{instr[31]}}, instr[31:20]};
      IMM_S: ext = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: ext = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J: ext = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_U: ext = {{32{instr[31]}}, instr[31:12], 12'b0};
      default: ext = '0;
    endcase
  end

  assign imm = ext[XLEN-1:0];

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - registered RV32I decode stage with valid/ready and flush
// Optional M-extension decode enabled by DECODE_MEXT_EN.
module instr_decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pc_out,
  output logic [AW-1:0]   rd,
  output logic [AW-1:0]   rs1,
  output logic [AW-1:0]   rs2,
  output logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      alu_ctrl,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_write,
  output logic [1:0]      result_src,
  output logic            branch,
  output logic            jump,
  output logic            illegal
);

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic            legal;
  ctrl_t           dec, ctrl_q;
  logic [XLEN-1:0] imm_d, imm_q, pc_q;
  logic [AW-1:0]   rd_q, rs1_q, rs2_q;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    case (opcode)
      OP_LOAD: begin
        dec.alu_src    = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_MEM;
        legal          = (f3 != 3'b011) && (f3[2:1] != 2'b11);
      end
      OP_STORE: begin
        dec.imm_src   = IMM_S;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        legal         = (f3 <= 3'b010);
      end
      OP_BRANCH: begin
        dec.imm_src  = IMM_B;
        dec.alu_ctrl = {1'b0, f3};
        dec.branch   = 1'b1;
        legal        = (f3[2:1] != 2'b01);
      end
      OP_JAL: begin
        dec.imm_src    = IMM_J;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PC4;
        legal          = (f3 == 3'b000);
      end
      OP_IMM: begin
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = {1'b0, f3};
        if (f3 == 3'b001 && f7 != F7_BASE) legal = 1'b0;
        if (f3 == 3'b101) begin
          if (f7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
          else if (f7 != F7_BASE) legal = 1'b0;
        end
      end
      OP_OP: begin
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = {1'b0, f3};
        if (f7 == F7_ALT) begin
          if (f3 == 3'b000) dec.alu_ctrl = ALU_SUB;
          else if (f3 == 3'b101) dec.alu_ctrl = ALU_SRA;
          else legal = 1'b0;
        end else if (f7 == F7_MULD) begin
`ifdef DECODE_MEXT_EN
          dec.alu_ctrl = {1'b1, f3};
`else
          legal = 1'b0;
`endif
        end else if (f7 != F7_BASE) begin
          legal = 1'b0;
        end
      end
      OP_LUI, OP_AUIPC: begin
        dec.imm_src   = IMM_U;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
    if (instr[11:7] == 5'd0) dec.reg_write = 1'b0;
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr  (instr),
    .imm_src(dec.imm_src),
    .imm    (imm_d)
  );

  assign in_ready = !out_valid || out_ready;

  // Flush outranks both capture and hold; the data registers keep stale contents behind out_valid=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      ctrl_q    <= '0;
      imm_q     <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      ctrl_q    <= dec;
      imm_q     <= imm_d;
      pc_q      <= pc_in;
      rd_q      <= AW'(instr[11:7]);
      rs1_q     <= AW'(instr[19:15]);
      rs2_q     <= AW'(instr[24:20]);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign pc_out     = pc_q;
  assign rd         = rd_q;
  assign rs1        = rs1_q;
  assign rs2        = rs2_q;
  assign imm        = imm_q;
  assign imm_src    = ctrl_q.imm_src;
  assign alu_ctrl   = ctrl_q.alu_ctrl;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_write  = ctrl_q.mem_write;
  assign result_src = ctrl_q.result_src;
  assign branch     = ctrl_q.branch;
  assign jump       = ctrl_q.jump;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - scoreboard bench for instr_decode_stage (either DECODE_MEXT_EN build)
module tb_instr_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  imm_src;
    logic [31:0] imm;
    logic [3:0]  alu_ctrl;
    logic        alu_src, reg_write, mem_write;
    logic [1:0]  result_src;
    logic        branch, jump, illegal;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc_in = '0;
  logic in_ready, out_valid, alu_src, reg_write, mem_write, branch, jump, illegal;
  logic [31:0] pc_out, imm;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] imm_src;
  logic [3:0] alu_ctrl;
  logic [1:0] result_src;

  int errors = 0, checks = 0;
  exp_t q[$];
  exp_t held_b;
  logic hold = 1'b0;

  instr_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc_in(pc_in), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .rd(rd), .rs1(rs1), .rs2(rs2), .imm_src(imm_src), .imm(imm),
    .alu_ctrl(alu_ctrl), .alu_src(alu_src), .reg_write(reg_write), .mem_write(mem_write),
    .result_src(result_src), .branch(branch), .jump(jump), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, got, exp);
    end
  endtask

  function automatic exp_t dut_bundle();
    return '{pc_out, rd, rs1, rs2, imm_src, imm, alu_ctrl, alu_src, reg_write,
             mem_write, result_src, branch, jump, illegal};
  endfunction

  // Reference decode: format letter + control flags from the instruction tables, immediate by arithmetic.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int s, v, fmt;
    logic [2:0] f3;
    logic [6:0] f7;
    logic ok;
    e = '0;
    e.pc = pc; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    f3 = w[14:12]; f7 = w[31:25]; s = int'($signed(w)); ok = 1'b1; fmt = 0;
    case (w[6:0])
      7'h03: begin ok = f3 inside {0, 1, 2, 4, 5}; e.alu_src = 1; e.reg_write = 1; e.result_src = 2'd1; end
      7'h23: begin ok = f3 inside {0, 1, 2}; fmt = 1; e.alu_src = 1; e.mem_write = 1; end
      7'h63: begin ok = f3 inside {0, 1, 4, 5, 6, 7}; fmt = 2; e.branch = 1; e.alu_ctrl = {1'b0, f3}; end
      7'h6F: begin fmt = 3; e.jump = 1; e.reg_write = 1; e.result_src = 2'd2; end
      7'h67: begin ok = (f3 == 0); e.jump = 1; e.reg_write = 1; e.result_src = 2'd2; e.alu_src = 1; end
      7'h13: begin
        e.alu_src = 1; e.reg_write = 1; e.alu_ctrl = {1'b0, f3};
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) begin ok = f7 inside {7'h00, 7'h20}; if (f7 == 7'h20) e.alu_ctrl = 4'd13; end
      end
      7'h33: begin
        e.reg_write = 1;
        if (f7 == 7'h00) e.alu_ctrl = {1'b0, f3};
        else if (f7 == 7'h20 && f3 == 0) e.alu_ctrl = 4'd8;
        else if (f7 == 7'h20 && f3 == 5) e.alu_ctrl = 4'd13;
`ifdef DECODE_MEXT_EN
        else if (f7 == 7'h01) e.alu_ctrl = {1'b1, f3};
`endif
        else ok = 1'b0;
      end
      7'h37, 7'h17: begin fmt = 4; e.alu_src = 1; e.reg_write = 1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e.alu_src = 0; e.reg_write = 0; e.mem_write = 0; e.result_src = 0;
      e.branch = 0; e.jump = 0; e.alu_ctrl = 0; fmt = 0; e.illegal = 1;
    end
    if (e.rd == 0) e.reg_write = 0;
    case (fmt)
      1: v = (s >>> 25) * 32 + int'(w[11:7]);
      2: v = (s >>> 31) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      3: v = (s >>> 31) * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      4: v = int'(w & 32'hFFFF_F000);
      default: v = s >>> 20;
    endcase
    e.imm_src = 3'(fmt);
    e.imm = 32'(v);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[6:0] = 7'h03;  1: w[6:0] = 7'h23;  2: w[6:0] = 7'h63;  3: w[6:0] = 7'h6F;
      4: w[6:0] = 7'h67;  5: w[6:0] = 7'h13;  6: w[6:0] = 7'h33;  7: w[6:0] = 7'h37;
      8: w[6:0] = 7'h17;  9: w[6:0] = 7'h0F;  10: w[6:0] = 7'h73; default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; 2: w[31:25] = 7'h01; default: ;
    endcase
    if ($urandom_range(0, 7) == 0) w[11:7] = 5'd0;
    return w;
  endfunction

  // One cycle of stimulus; the expected bundle is queued when the offer should be taken.
  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic exp_rdy;
    @(posedge clk); #1;
    in_valid = v; instr = w; pc_in = pc; out_ready = ordy; flush = fl;
    exp_rdy = (q.size() == 0) || ordy;
    @(negedge clk); #1;
    if (fl) q.delete();
    else if (v && exp_rdy) q.push_back(model(w, pc));
  endtask

  always @(negedge clk) begin
    exp_t cur, e;
    if (rst) begin
      hold <= 1'b0;
    end else begin
      cur = dut_bundle();
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'((q.size() == 0) || out_ready));
      if (hold && out_valid) chk("hold_stable", 128'(cur), 128'(held_b));
      if (out_valid && out_ready && !flush && q.size() != 0) begin
        e = q.pop_front();
        chk("bundle", 128'(cur), 128'(e));
      end
      hold   <= out_valid && !out_ready && !flush;
      held_b <= cur;
    end
  end

  initial begin
    #1;
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_bundle", 128'(dut_bundle()), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("in_ready_after_reset", 128'(in_ready), 128'(1));

    drive(1, 32'h0081_2283, 32'h0000_0100, 1, 0);
    drive(1, 32'h0051_A223, 32'h0000_0104, 1, 0);
    drive(1, 32'hFE00_0EE3, 32'h0000_0108, 1, 0);
    drive(1, 32'h1234_50B7, 32'h0000_010C, 1, 0);
    drive(1, 32'h0220_81B3, 32'h0000_0110, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    drive(1, 32'h0011_0093, 32'h0000_0200, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'h4020_D193, 32'h0000_0204, 0, 0);
    drive(1, 32'h4020_D193, 32'h0000_0204, 1, 0);
    drive(0, 32'h0, 32'h0, 1, 0);

    drive(1, 32'h0000_006F, 32'h0000_0300, 0, 0);
    drive(1, 32'h0000_8067, 32'h0000_0304, 0, 1);
    drive(0, 32'h0, 32'h0, 1, 0);

    for (int i = 0; i < 3000; i++) begin
      logic fl;
      fl = ($urandom_range(0, 19) == 0);
      drive(logic'($urandom_range(0, 3) != 0), rand_instr(), $urandom,
            fl ? 1'b0 : logic'($urandom_range(0, 9) < 7), fl);
    end
    drive(0, 32'h0, 32'h0, 1, 0);

    drive(1, 32'h0081_2283, 32'h0000_0400, 0, 0);
    drive(0, 32'h0, 32'h0, 0, 0);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_reset_out_valid", 128'(out_valid), 128'(0));
    chk("async_reset_bundle", 128'(dut_bundle()), 128'(0));
    q.delete();
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 3; i++) drive(0, 32'h0, 32'h0, 1, 0);
    chk("queue_drained", 128'(q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
